// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared widths, state type and one-hot helper for the pulse decoder
package decoder_pkg;

   localparam int CODE_W = 4;
   localparam int OUT_W  = 16;

   typedef enum logic {
      DEC_IDLE,
      DEC_ACTIVE
   } dec_state_t;

   function automatic logic [OUT_W-1:0] onehot16(input logic [CODE_W-1:0] code);
      onehot16 = 16'h0001 << code;
   endfunction

endpackage

// File: rtl/dec_hold_timer.sv
// rtl/dec_hold_timer.sv - loadable down-counter that parks at zero
module dec_hold_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             clear,
   output logic             zero
);

   logic [CNT_W-1:0] cnt;

   // clear beats load so an abort can never be overridden by a same-edge reload
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/decoder_4to16_pulse.sv
// rtl/decoder_4to16_pulse.sv - registered 4-to-16 one-hot decoder with programmable pulse length
// Optional abort input enabled by DECODER_PULSE_ABORT_EN.
module decoder_4to16_pulse
   import decoder_pkg::*;
#(
   parameter int PULSE_LEN = 4,
   parameter int CNT_W     = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CODE_W-1:0] in_code,
   input  logic              in_valid,
`ifdef DECODER_PULSE_ABORT_EN
   input  logic              abort,
`endif
   output logic              in_ready,
   output logic [OUT_W-1:0]  out,
   output logic              out_valid,
   output logic              busy
);

   dec_state_t       state, next_state;
   logic [OUT_W-1:0] out_r, next_out;
   logic             accept, kill;
   logic             tmr_load, tmr_clear, tmr_zero;

`ifdef DECODER_PULSE_ABORT_EN
   assign kill = abort;
`else
   assign kill = 1'b0;
`endif

   dec_hold_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (CNT_W'(PULSE_LEN - 1)),
      .clear    (tmr_clear),
      .zero     (tmr_zero)
   );

   // the last hold cycle (counter at zero) can take the next code, giving gapless back-to-back pulses
   always_comb begin
      if (rst) begin
         in_ready = 1'b1;
      end else if (kill) begin
         in_ready = 1'b0;
      end else if (state == DEC_IDLE) begin
         in_ready = 1'b1;
      end else begin
         in_ready = tmr_zero;
      end
   end

   assign accept = in_valid && in_ready;

   always_comb begin
      next_state = state;
      next_out   = out_r;
      tmr_load   = 1'b0;
      tmr_clear  = 1'b0;
      case (state)
         DEC_IDLE: begin
            if (accept) begin
               next_state = DEC_ACTIVE;
               next_out   = onehot16(in_code);
               tmr_load   = 1'b1;
            end
         end
         DEC_ACTIVE: begin
            if (kill) begin
               next_state = DEC_IDLE;
               next_out   = '0;
               tmr_clear  = 1'b1;
            end else if (tmr_zero) begin
               if (accept) begin
                  next_out = onehot16(in_code);
                  tmr_load = 1'b1;
               end else begin
                  next_state = DEC_IDLE;
                  next_out   = '0;
               end
            end
         end
         default: begin
            next_state = DEC_IDLE;
            next_out   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= DEC_IDLE;
         out_r <= '0;
      end else begin
         state <= next_state;
         out_r <= next_out;
      end
   end

   assign out       = out_r;
   assign out_valid = |out_r;
   assign busy      = (state == DEC_ACTIVE);

endmodule

// File: tb/tb_decoder_4to16_pulse.sv
// tb/tb_decoder_4to16_pulse.sv - directed bench for decoder_4to16_pulse (PULSE_LEN 4 and 1 side by side)
module tb_decoder_4to16_pulse;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        abort;
   logic [3:0]  in_code;
   logic        rdy_a, rdy_b;
   logic [15:0] out_a, out_b;
   logic        ov_a, ov_b, busy_a, busy_b;

   int n_vec  = 0;
   int n_miss = 0;

   // model: cycles left to show the current code; 0 means idle
   int         rem [2];
   logic [3:0] mcode [2];
   int         plen [2];
   bit         started = 1'b0;

   always #5 clk = ~clk;

   decoder_4to16_pulse #(.PULSE_LEN(4), .CNT_W(8)) u_dut_a (
      .clk       (clk),
      .rst       (rst),
      .in_code   (in_code),
      .in_valid  (in_valid),
`ifdef DECODER_PULSE_ABORT_EN
      .abort     (abort),
`endif
      .in_ready  (rdy_a),
      .out       (out_a),
      .out_valid (ov_a),
      .busy      (busy_a)
   );

   decoder_4to16_pulse #(.PULSE_LEN(1), .CNT_W(8)) u_dut_b (
      .clk       (clk),
      .rst       (rst),
      .in_code   (in_code),
      .in_valid  (in_valid),
`ifdef DECODER_PULSE_ABORT_EN
      .abort     (abort),
`endif
      .in_ready  (rdy_b),
      .out       (out_b),
      .out_valid (ov_b),
      .busy      (busy_b)
   );

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] exp_out(input int i);
      return (rem[i] > 0) ? (16'h0001 << mcode[i]) : 16'h0000;
   endfunction

   function automatic logic exp_ready(input int i);
      if (rst) return 1'b1;
      if (abort) return 1'b0;
      return rem[i] <= 1;
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst || abort) begin
            rem[i] <= 0;
         end else if (in_valid && rem[i] <= 1) begin
            rem[i]   <= plen[i];
            mcode[i] <= in_code;
         end else if (rem[i] > 0) begin
            rem[i] <= rem[i] - 1;
         end
      end
      if (rst) started <= 1'b1;
   end

   always @(negedge clk) begin
      if (started) begin
         chk("m_out_a",   out_a,  exp_out(0));
         chk("m_ov_a",    16'(ov_a),   16'(rem[0] > 0));
         chk("m_busy_a",  16'(busy_a), 16'(rem[0] > 0));
         chk("m_rdy_a",   16'(rdy_a),  16'(exp_ready(0)));
         chk("m_onehot_a", 16'($countones(out_a) <= 1), 16'd1);
         chk("m_out_b",   out_b,  exp_out(1));
         chk("m_ov_b",    16'(ov_b),   16'(rem[1] > 0));
         chk("m_rdy_b",   16'(rdy_b),  16'(exp_ready(1)));
      end
   end

   task automatic step(input logic r, input logic v, input logic [3:0] c, input logic a);
      rst      = r;
      in_valid = v;
      in_code  = c;
      abort    = a;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, 4'd0, 1'b0);
   endtask

   initial begin
      plen[0] = 4;
      plen[1] = 1;
      rem[0] = 0;
      rem[1] = 0;
      mcode[0] = '0;
      mcode[1] = '0;
      rst = 1'b1; in_valid = 1'b1; in_code = 4'd7; abort = 1'b0;

      // reset held with a pending request
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 1'b1, 4'd7, 1'b0);
         chk("rst_out", out_a, 16'h0000);
         chk("rst_rdy", 16'(rdy_a), 16'd1);
         chk("rst_busy", 16'(busy_a), 16'd0);
      end
      step(1'b0, 1'b0, 4'd0, 1'b0);
      chk("post_rst_out", out_a, 16'h0000);

      // single pulse, code 5
      step(1'b0, 1'b1, 4'd5, 1'b0);
      chk("p5_out0", out_a, 16'h0020);
      chk("p5_rdy0", 16'(rdy_a), 16'd0);
      chk("p5_len1", out_b, 16'h0020);
      idle(2);
      chk("p5_out2", out_a, 16'h0020);
      chk("p5_rdy2", 16'(rdy_a), 16'd0);
      chk("p5_len1_off", out_b, 16'h0000);
      idle(1);
      chk("p5_out3", out_a, 16'h0020);
      chk("p5_rdy3", 16'(rdy_a), 16'd1);
      idle(1);
      chk("p5_end", out_a, 16'h0000);

      // back-to-back 2 then 14 with no gap
      step(1'b0, 1'b1, 4'd2, 1'b0);
      idle(3);
      chk("b2b_first", out_a, 16'h0004);
      step(1'b0, 1'b1, 4'd14, 1'b0);
      chk("b2b_second", out_a, 16'h4000);
      idle(3);
      chk("b2b_second_last", out_a, 16'h4000);
      idle(1);
      chk("b2b_end", out_a, 16'h0000);

      // code 9 held while blocked by a code 3 pulse
      step(1'b0, 1'b1, 4'd3, 1'b0);
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b1, 4'd9, 1'b0);
         chk("blk_hold", out_a, 16'h0008);
      end
      step(1'b0, 1'b1, 4'd9, 1'b0);
      chk("blk_taken", out_a, 16'h0200);
      idle(4);
      chk("blk_end", out_a, 16'h0000);

      // reset in the second cycle of a code 0 pulse
      step(1'b0, 1'b1, 4'd0, 1'b0);
      chk("rmid_out0", out_a, 16'h0001);
      step(1'b1, 1'b1, 4'd6, 1'b0);
      chk("rmid_cleared", out_a, 16'h0000);
      chk("rmid_rdy", 16'(rdy_a), 16'd1);
      step(1'b0, 1'b1, 4'd6, 1'b0);
      chk("rmid_restart", out_a, 16'h0040);
      idle(3);
      chk("rmid_full", out_a, 16'h0040);
      idle(1);
      chk("rmid_end", out_a, 16'h0000);

      // same code twice: line stays high for 8 cycles
      step(1'b0, 1'b1, 4'd11, 1'b0);
      idle(3);
      step(1'b0, 1'b1, 4'd11, 1'b0);
      idle(3);
      chk("same_last", out_a, 16'h0800);
      idle(1);
      chk("same_end", out_a, 16'h0000);

      // PULSE_LEN=1 instance decodes one code per cycle
      step(1'b0, 1'b1, 4'd1, 1'b0);
      chk("len1_c1", out_b, 16'h0002);
      step(1'b0, 1'b1, 4'd15, 1'b0);
      chk("len1_c15", out_b, 16'h8000);
      chk("len1_rdy", 16'(rdy_b), 16'd1);
      idle(5);

`ifdef DECODER_PULSE_ABORT_EN
      // abort a code 15 pulse while a new request is offered
      step(1'b0, 1'b1, 4'd15, 1'b0);
      chk("ab_out0", out_a, 16'h8000);
      step(1'b0, 1'b1, 4'd1, 1'b1);
      chk("ab_cleared", out_a, 16'h0000);
      chk("ab_rdy_blocked", 16'(rdy_a), 16'd0);
      step(1'b0, 1'b0, 4'd0, 1'b0);
      chk("ab_still_idle", out_a, 16'h0000);
      chk("ab_rdy_after", 16'(rdy_a), 16'd1);
      idle(2);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/decoder_4to16_pulse.md
Name: decoder_4to16_pulse

Overview:
Registered 4-to-16 one-hot decoder; the inverse of the team's 16-to-4 priority encoder.
- Accepts a 4-bit code with a valid/ready handshake.
- Drives the matching one-hot line for a programmable number of cycles, then releases it.
- Sits downstream of the encoder (or any code source) to regenerate select/strobe lines, e.g. for interrupt acknowledge or channel enables.

Parameters:
PULSE_LEN, 4, cycles each decoded one-hot output is held high; legal range 1..255.
CNT_W, 8, width of the internal hold counter; must satisfy 2^CNT_W > PULSE_LEN.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst  input  1  synchronous, active-high reset.
in_code  input  4  code to decode; 0..15 selects out[0]..out[15].
in_valid  input  1  in_code is valid this cycle.
in_ready  output  1  block can accept a code this cycle.
out  output  16  registered one-hot output; all zero when idle.
out_valid  output  1  high whenever out is non-zero; equals |out.
busy  output  1  high in ACTIVE state.

Behaviour:
Reset and handshake
- Reset: synchronous; rst high at a rising edge forces state=IDLE, out=16'h0000, out_valid=0, busy=0, counter=0.
- in_ready=1 during reset and in IDLE.
- Accept condition: in_valid && in_ready at a rising edge.
- Latency: code accepted at edge N; out=(16'h0001 << in_code) is visible after edge N, i.e. 1 cycle.

States
- IDLE: in_ready=1, out=0.
  - On accept: state -> ACTIVE, counter <= PULSE_LEN-1.
- ACTIVE: out holds the one-hot value; busy=1.
  - counter decrements by 1 per cycle while non-zero.
  - in_ready = (counter==0). The last hold cycle can accept the next code.
  - counter==0, no accept: out <= 0, state -> IDLE.
  - counter==0, accept: out <= new one-hot value, counter <= PULSE_LEN-1, state stays ACTIVE. Outputs stay continuous back-to-back with no gap cycle.
- in_valid while in_ready=0 is ignored. No code is stored; the source must hold in_code and in_valid until accepted.

Boundary cases
- PULSE_LEN=1: counter is always 0, so in_ready stays 1. The block decodes one code per cycle with 1-cycle pulses.
- Same code accepted back-to-back: the out line stays high continuously for 2*PULSE_LEN cycles.
- rst asserted mid-pulse: out clears on that edge. Any simultaneous accept is discarded; reset has priority over everything.
- Output invariants: out never has more than one bit set, and out_valid == |out on every cycle.
- Counter arithmetic: unsigned CNT_W bits, never decremented below 0.

Optional Feature:
Macro DECODER_PULSE_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort high at an edge in ACTIVE: out <= 0, counter <= 0, state -> IDLE.
  - abort takes priority over a simultaneous accept, which is dropped; in_ready is forced 0 while abort=1.
  - abort in IDLE: no effect, other than blocking acceptance that cycle.
- Undefined: port absent; pulses always run to completion or reset.

Decomposition:
- Package decoder_pkg:
  - CODE_W=4, OUT_W=16.
  - State enum dec_state_t {DEC_IDLE, DEC_ACTIVE}.
  - Function onehot16(code) returning 16'h1 << code.
- One sub-module, dec_hold_timer: loadable down-counter.
  - Ports: clk, rst, load, load_val[CNT_W-1:0], clear, zero.
  - Instantiated once. The FSM and output register stay in the top.

Test Plan:
1. Reset: hold rst 3 cycles with in_valid=1, in_code=7 -> out=0, out_valid=0, busy=0, in_ready=1 throughout; no pulse after release unless in_valid is still high.
2. Single pulse, PULSE_LEN=4: accept code 5 at edge N -> out=16'h0020 for edges N+1..N+4, out=0 after N+5; in_ready low for edges N+1..N+3.
3. Back-to-back: code 2 then code 14, second presented on the last hold cycle -> out=16'h0004 for 4 cycles, then 16'h4000 for 4 cycles, no zero cycle between.
4. Blocked request: in_valid=1, code 9 asserted mid-pulse -> no effect until in_ready=1, then accepted; out=16'h0200 starts exactly one cycle after acceptance.
5. Reset mid-pulse: rst on the 2nd cycle of code 0 pulse -> out=0 on that edge; next accept restarts a full PULSE_LEN pulse.
6. Abort (with DECODER_PULSE_ABORT_EN): abort on cycle 2 of a code-15 pulse together with in_valid=1 -> out=0 next edge, new code not taken; in_ready=1 the following cycle.
